// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA test-pattern datapath.
package vga_pkg;
    localparam int CNT_W   = 11;
    localparam int PAT_W   = 3;
    localparam int COLOR_W = 3;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int PATTERN_BLACK   = 0;
    localparam int PATTERN_RED     = 1;
    localparam int PATTERN_GREEN   = 2;
    localparam int PATTERN_BLUE    = 3;
    localparam int PATTERN_YELLOW  = 4;
    localparam int PATTERN_CYAN    = 5;
    localparam int PATTERN_MAGENTA = 6;
    localparam int PATTERN_WHITE   = 7;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [PAT_W-1:0]   pattern_t;
    typedef logic [COLOR_W-1:0] color_t;
endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// Bundle between the sequencer, its pattern generator and the request source.
interface vga_pattern_sequencer_if;
    import vga_pkg::*;

    logic     i_auto_en;
    logic     i_next;
    logic     i_sel_valid;
    pattern_t i_sel_pattern;
    color_t   i_red;
    color_t   i_green;
    color_t   i_blue;

    cnt_t     o_x;
    cnt_t     o_y;
    pattern_t o_pattern;
    logic     o_frame_start;
    logic     o_hsync;
    logic     o_vsync;
    logic     o_active;
    color_t   o_red;
    color_t   o_green;
    color_t   o_blue;

    modport master (
        output i_auto_en, i_next, i_sel_valid, i_sel_pattern, i_red, i_green, i_blue,
        input  o_x, o_y, o_pattern, o_frame_start, o_hsync, o_vsync, o_active,
               o_red, o_green, o_blue
    );

    modport slave (
        input  i_auto_en, i_next, i_sel_valid, i_sel_pattern, i_red, i_green, i_blue,
        output o_x, o_y, o_pattern, o_frame_start, o_hsync, o_vsync, o_active,
               o_red, o_green, o_blue
    );
endinterface

// File: rtl/vga_sync_counter.sv
// Raster h/v counters with combinational sync windows, visible-area and frame flags.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic clk,
    input  logic rst_n,
    output cnt_t h,
    output cnt_t v,
    output logic hsync_n,
    output logic vsync_n,
    output logic active,
    output logic frame_end,
    output logic frame_start
);
    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FRONT);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FRONT);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + cnt_t'(1);
        end else begin
            h <= h + cnt_t'(1);
        end
    end

    assign hsync_n     = !((h >= HS_START) && (h < HS_END));
    assign vsync_n     = !((v >= VS_START) && (v < VS_END));
    assign active      = (h < H_VIS) && (v < V_VIS);
    assign frame_end   = (h == H_LAST) && (v == V_LAST);
    assign frame_start = (h == '0) && (v == '0);
endmodule

// File: rtl/vga_pattern_sequencer.sv
// VGA test-pattern sequencer: raster timing, frame-synchronous pattern selection
// and a registered, blanked colour/sync output stage.
module vga_pattern_sequencer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE           = DEF_H_ACTIVE,
    parameter int H_FRONT            = DEF_H_FRONT,
    parameter int H_SYNC             = DEF_H_SYNC,
    parameter int H_BACK             = DEF_H_BACK,
    parameter int V_ACTIVE           = DEF_V_ACTIVE,
    parameter int V_FRONT            = DEF_V_FRONT,
    parameter int V_SYNC             = DEF_V_SYNC,
    parameter int V_BACK             = DEF_V_BACK,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int NUM_PATTERNS       = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    vga_pattern_sequencer_if.slave  bus
);
    localparam int                FC_W    = $clog2(FRAMES_PER_PATTERN + 1);
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FRAMES_PER_PATTERN - 1);

    function automatic pattern_t next_pattern(input pattern_t p);
        return (int'(p) >= NUM_PATTERNS - 1) ? pattern_t'(PATTERN_BLACK) : p + pattern_t'(1);
    endfunction

    function automatic pattern_t map_sel(input pattern_t s);
        return (int'(s) >= NUM_PATTERNS) ? pattern_t'(PATTERN_BLACK) : s;
    endfunction

    // Stage 0: raster counters and pattern state, generator answers in this cycle
    cnt_t            h_p0, v_p0;
    logic            hsync_n_p0, vsync_n_p0, vld_p0, frame_end_p0, frame_start_p0;
    pattern_t        pattern_p0, sel_val_p0;
    logic            pending_sel_p0, pending_next_p0;
    logic [FC_W-1:0] frame_cnt_p0;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_sync (
        .clk         (i_clk),
        .rst_n       (i_reset_n),
        .h           (h_p0),
        .v           (v_p0),
        .hsync_n     (hsync_n_p0),
        .vsync_n     (vsync_n_p0),
        .active      (vld_p0),
        .frame_end   (frame_end_p0),
        .frame_start (frame_start_p0)
    );

    // Requests on the frame-end cycle itself are merged so they land on that edge.
    logic     sel_req, next_req, auto_adv;
    pattern_t sel_target;

    assign sel_req    = pending_sel_p0 || bus.i_sel_valid;
    assign sel_target = bus.i_sel_valid ? map_sel(bus.i_sel_pattern) : sel_val_p0;
    assign next_req   = pending_next_p0 || bus.i_next;
    assign auto_adv   = bus.i_auto_en && (frame_cnt_p0 == FC_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pattern_p0      <= pattern_t'(PATTERN_BLACK);
            sel_val_p0      <= '0;
            pending_sel_p0  <= 1'b0;
            pending_next_p0 <= 1'b0;
            frame_cnt_p0    <= '0;
        end else if (frame_end_p0) begin
            if (sel_req) begin
                pattern_p0   <= sel_target;
                frame_cnt_p0 <= '0;
            end else if (next_req || auto_adv) begin
                pattern_p0   <= next_pattern(pattern_p0);
                frame_cnt_p0 <= '0;
            end else if (bus.i_auto_en) begin
                frame_cnt_p0 <= frame_cnt_p0 + 1'b1;
            end else begin
                frame_cnt_p0 <= '0;
            end
            pending_sel_p0  <= 1'b0;
            pending_next_p0 <= 1'b0;
        end else begin
            pending_sel_p0  <= sel_req;
            sel_val_p0      <= sel_target;
            pending_next_p0 <= next_req;
            if (!bus.i_auto_en) frame_cnt_p0 <= '0;
        end
    end

    assign bus.o_x           = h_p0;
    assign bus.o_y           = v_p0;
    assign bus.o_pattern     = pattern_p0;
    assign bus.o_frame_start = frame_start_p0;

    // Stage 1: syncs, visible flag and blanked colours, one clock behind x/y
    logic   hsync_p1, vsync_p1, vld_p1;
    color_t red_p1, green_p1, blue_p1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            vld_p1   <= 1'b0;
            red_p1   <= '0;
            green_p1 <= '0;
            blue_p1  <= '0;
        end else begin
            hsync_p1 <= hsync_n_p0;
            vsync_p1 <= vsync_n_p0;
            vld_p1   <= vld_p0;
            red_p1   <= vld_p0 ? bus.i_red   : '0;
            green_p1 <= vld_p0 ? bus.i_green : '0;
            blue_p1  <= vld_p0 ? bus.i_blue  : '0;
        end
    end

    assign bus.o_hsync = hsync_p1;
    assign bus.o_vsync = vsync_p1;
    assign bus.o_active = vld_p1;
    assign bus.o_red   = red_p1;
    assign bus.o_green = green_p1;
    assign bus.o_blue  = blue_p1;
endmodule
